ft2_tx_ctrl: RTL and testbench

Drains the byte-wide FT2 transmit FIFO and drives the write side of the FT2232H synchronous-245 bus toward the host. It sits between the FIFO's read port (1-cycle read latency) and the FT2 pads. A 3-entry skid buffer lets the block sustain one byte per clock while absorbing host back-pressure on `ft_txe_n` without losing bytes. It also reports a transferred-byte count and, optionally, flushes short packets with SIWU#.

---
 rtl/ft2_pkg.sv | 14 +
 rtl/ft2_skid_buf.sv | 56 +++++
 rtl/ft2_tx_ctrl.sv | 98 +++++++++
 tb/tb_ft2_tx_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft2_pkg.sv
// Shared constants and types for the FT2 transmit path.
package ft2_pkg;

    localparam int FT2_DATA_W        = 8;
    localparam int FT2_SKID_DEPTH    = 3;
    localparam int FT2_SIWU_IDLE_DEF = 64;

    // Occupancy counter width: holds 0..FT2_SKID_DEPTH.
    localparam int FT2_CNT_W = $clog2(FT2_SKID_DEPTH + 1);

    typedef logic [FT2_DATA_W-1:0] ft2_byte_t;
    typedef logic [FT2_CNT_W-1:0]  ft2_cnt_t;

endpackage

// File: rtl/ft2_skid_buf.sv
// Three-entry register queue between the FIFO read port and the FT2 pads.
// Entry 0 is always the head, so the head output comes straight from a flop.
// The empty flag is also a flop, so it can drive WR# directly.
module ft2_skid_buf
    import ft2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FT2_DATA_W-1:0] push_data,
    input  logic                  pop,
    output logic [FT2_CNT_W-1:0]  count,
    output logic                  empty,
    output logic [FT2_DATA_W-1:0] head
);

    ft2_byte_t entry_q [FT2_SKID_DEPTH];
    ft2_cnt_t  count_next;
    ft2_cnt_t  wr_idx;

    // Next occupancy, and the tail slot that is free after this edge's pop.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        count_next = count + ft2_cnt_t'(push) - ft2_cnt_t'(pop);
        wr_idx     = count - ft2_cnt_t'(pop);
    end

    // Shift toward the head on pop, write the tail on push, and track occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entries are plain flops rather than a RAM, so they take the reset;
            // entry 0 drives ft_data, which must read 0x00 out of reset.
            for (int i = 0; i < FT2_SKID_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count <= '0;
            empty <= 1'b1;
        end else begin
            if (pop) begin
                for (int i = 0; i < FT2_SKID_DEPTH - 1; i++) begin
                    entry_q[i] <= entry_q[i+1];
                end
            end
            // NOTE: non-blocking assignments; on a simultaneous pop and push the later
            // write to entry_q[wr_idx] wins, which is exactly the slot the shift vacated.
            if (push) begin
                entry_q[wr_idx] <= push_data;
            end
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

    assign head = entry_q[0];

endmodule

// File: rtl/ft2_tx_ctrl.sv
// FT2 transmit controller: drains the byte FIFO into the FT2232H synchronous-245
// write port through a 3-entry skid buffer, counts accepted bytes, and optionally
// flushes short packets with SIWU#.
// Build option: define FT2_SIWU_EN to build the idle-flush (SIWU#) logic.
module ft2_tx_ctrl
    import ft2_pkg::*;
#(
    parameter int SIWU_IDLE = FT2_SIWU_IDLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [FT2_DATA_W-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  ft_txe_n,
    output logic                  ft_wr_n,
    output logic [FT2_DATA_W-1:0] ft_data,
    output logic                  ft_siwu_n,
    output logic [31:0]           tx_count
);

    logic                 inflight;
    logic                 accept;
    logic                 buf_empty;
    logic [FT2_CNT_W-1:0] buf_count;
    logic [FT2_CNT_W:0]   pending;

    // Buffered plus in-flight bytes; a read is issued only when a slot is guaranteed.
    assign pending    = {1'b0, buf_count} + {{FT2_CNT_W{1'b0}}, inflight};
    assign fifo_rd_en = ~rst & ~fifo_empty & (pending < (FT2_CNT_W + 1)'(FT2_SKID_DEPTH));

    // WR# is the registered empty flag of the buffer; the host takes the head byte
    // on any edge where WR# and TXE# are both low.
    assign ft_wr_n = buf_empty;
    assign accept  = ~buf_empty & ~ft_txe_n;

    ft2_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (accept),
        .count     (buf_count),
        .empty     (buf_empty),
        .head      (ft_data)
    );

    // Track the read whose data arrives next clock, and count host-accepted bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tx_count <= '0;
        end else begin
            inflight <= fifo_rd_en & ~fifo_empty;
            if (accept) begin
                tx_count <= tx_count + 32'd1;
            end
        end
    end

`ifdef FT2_SIWU_EN
    localparam int IDLE_W = $clog2(SIWU_IDLE + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              sent_flag;
    logic              idle;

    // Nothing buffered, nothing in flight, nothing waiting, and data sent since the last flush.
    assign idle = (buf_count == '0) & ~inflight & fifo_empty & sent_flag;

    // Count idle clocks after traffic and fire a single-clock SIWU# pulse on reaching SIWU_IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            sent_flag <= 1'b0;
            ft_siwu_n <= 1'b1;
        end else begin
            ft_siwu_n <= 1'b1;
            if (accept) begin
                idle_cnt  <= '0;
                sent_flag <= 1'b1;
            end else if (idle) begin
                if (idle_cnt == IDLE_W'(SIWU_IDLE - 1)) begin
                    ft_siwu_n <= 1'b0;
                    idle_cnt  <= '0;
                    sent_flag <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end
`else
    // No flush logic in this build; SIWU_IDLE only folds into the constant so it stays referenced.
    assign ft_siwu_n = 1'b1 | (SIWU_IDLE == 0);
`endif

endmodule

// File: tb/tb_ft2_tx_ctrl.sv
// Self-checking bench for ft2_tx_ctrl. The FIFO is a queue model; every byte it
// hands out joins an "owed to host" queue, and the host must receive exactly those
// bytes in order. The read-issue rule is checked against that queue's occupancy.
module tb_ft2_tx_ctrl;

    localparam int IDLE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en;
    logic        ft_txe_n = 1'b1;
    logic        ft_wr_n;
    logic [7:0]  ft_data;
    logic        ft_siwu_n;
    logic [31:0] tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ft2_tx_ctrl #(.SIWU_IDLE(IDLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .ft_txe_n     (ft_txe_n),
        .ft_wr_n      (ft_wr_n),
        .ft_data      (ft_data),
        .ft_siwu_n    (ft_siwu_n),
        .tx_count     (tx_count)
    );

    // Reference model state
    logic [7:0]  fifo_q[$];   // bytes still inside the FIFO
    logic [7:0]  owed_q[$];   // bytes read from the FIFO, not yet taken by the host
    logic [7:0]  got_q[$];    // bytes the host took, in order
    logic [31:0] mdl_count = 32'd0;
    int          cyc = 0;
    logic        pend_rst = 1'b1;
    logic        pend_rd  = 1'b0;
    logic        pend_acc = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;

    // Mid-cycle monitor: sample what the next edge will do and check invariants.
    always @(negedge clk) begin
        pend_rst = rst;
        pend_rd  = fifo_rd_en && !fifo_empty;
        pend_acc = !ft_wr_n && !ft_txe_n;

        n_checks++;
        if (fifo_rd_en !== (!rst && !fifo_empty && owed_q.size() < 3)) begin
            n_fail++;
            $display("FAIL issue_rule cyc=%0d: fifo_rd_en=%b owed=%0d empty=%b rst=%b",
                     cyc, fifo_rd_en, owed_q.size(), fifo_empty, rst);
        end

        if (hold_prev) begin
            n_checks++;
            if (ft_wr_n !== 1'b0 || ft_data !== data_prev) begin
                n_fail++;
                $display("FAIL hold cyc=%0d: wr_n=%b data=%02h required wr_n=0 data=%02h",
                         cyc, ft_wr_n, ft_data, data_prev);
            end
        end

        if (pend_acc && !rst) begin
            n_checks++;
            if (owed_q.size() == 0) begin
                n_fail++;
                $display("FAIL accept_order cyc=%0d: host took %02h but nothing was owed", cyc, ft_data);
            end else if (ft_data !== owed_q[0]) begin
                n_fail++;
                $display("FAIL accept_order cyc=%0d: data=%02h required=%02h", cyc, ft_data, owed_q[0]);
            end
            got_q.push_back(ft_data);
        end

        n_checks++;
        if (tx_count !== mdl_count) begin
            n_fail++;
            $display("FAIL tx_count cyc=%0d: got=%08h required=%08h", cyc, tx_count, mdl_count);
        end

`ifndef FT2_SIWU_EN
        n_checks++;
        if (ft_siwu_n !== 1'b1) begin
            n_fail++;
            $display("FAIL siwu_tied cyc=%0d: ft_siwu_n=%b required 1", cyc, ft_siwu_n);
        end
`endif

        hold_prev = !ft_wr_n && ft_txe_n && !rst;
        data_prev = ft_data;
    end

    // FIFO model and scoreboard update, just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pend_rst) begin
            fifo_q.delete();
            owed_q.delete();
            mdl_count = 32'd0;
            fifo_rd_data = 8'($urandom);
        end else begin
            if (pend_acc) begin
                void'(owed_q.pop_front());
                mdl_count = mdl_count + 32'd1;
            end
            if (pend_rd) begin
                fifo_rd_data = fifo_q.pop_front();
                owed_q.push_back(fifo_rd_data);
            end else begin
                fifo_rd_data = 8'($urandom);
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (ft_wr_n !== 1'b1 || ft_data !== 8'h00 || ft_siwu_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: wr_n=%b data=%02h siwu_n=%b required 1/00/1",
                     ft_wr_n, ft_data, ft_siwu_n);
        end
        n_checks++;
        if (tx_count !== 32'd0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count: tx_count=%08h rd_en=%b required 0/0", tx_count, fifo_rd_en);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_burst();
        int first_rd;
        int first_wr;
        int last_wr;
        int n_low;
        first_rd = -1;
        first_wr = -1;
        last_wr  = -1;
        n_low    = 0;
        got_q.delete();
        ft_txe_n = 1'b0;
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (first_rd < 0 && fifo_rd_en) first_rd = cyc;
            if (!ft_wr_n) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                n_low++;
            end
        end
        n_checks++;
        if (first_rd < 0 || first_wr - first_rd !== 2) begin
            n_fail++;
            $display("FAIL burst_latency: first rd_en cyc=%0d first wr_n low cyc=%0d required gap 2",
                     first_rd, first_wr);
        end
        n_checks++;
        if (n_low !== 16 || last_wr - first_wr + 1 !== 16) begin
            n_fail++;
            $display("FAIL burst_contiguous: low clocks=%0d span=%0d required 16/16",
                     n_low, last_wr - first_wr + 1);
        end
        n_checks++;
        if (got_q.size() !== 16) begin
            n_fail++;
            $display("FAIL burst_size: got %0d bytes required 16", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got_q[i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL burst_data[%0d]: got=%02h required=%02h", i, got_q[i], 8'(i + 1));
                end
            end
        end
        n_checks++;
        if (tx_count !== 32'd16) begin
            n_fail++;
            $display("FAIL burst_tx_count: got=%08h required=00000010", tx_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] sent[$];
        got_q.delete();
        for (int i = 0; i < 24; i++) begin
            sent.push_back(8'($urandom));
            fifo_q.push_back(sent[i]);
        end
        for (int c = 0; c < 300 && got_q.size() < 24; c++) begin
            tick();
            if (c >= 8 && c < 13) ft_txe_n = 1'b1;
            else ft_txe_n = ($urandom_range(0, 3) == 0);
            if (c == 12) begin
                @(negedge clk);
                n_checks++;
                if (fifo_rd_en !== 1'b0 || ft_wr_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall: rd_en=%b wr_n=%b required 0/0 after 5 held clocks",
                             fifo_rd_en, ft_wr_n);
                end
            end
        end
        ft_txe_n = 1'b0;
        n_checks++;
        if (got_q.size() !== 24) begin
            n_fail++;
            $display("FAIL bp_size: got %0d bytes required 24", got_q.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                n_checks++;
                if (got_q[i] !== sent[i]) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got=%02h required=%02h", i, got_q[i], sent[i]);
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_gap();
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        got_q.delete();
        ft_txe_n = 1'b0;
        fifo_q.push_back(b0);
        for (int c = 0; c < 20 && got_q.size() < 1; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (ft_wr_n !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_wr_n[%0d]: wr_n=%b required 1", c, ft_wr_n);
            end
        end
        fifo_q.push_back(b1);
        for (int c = 0; c < 20 && got_q.size() < 2; c++) @(negedge clk);
        n_checks++;
        if (got_q.size() !== 2) begin
            n_fail++;
            $display("FAIL gap_size: got %0d bytes required 2", got_q.size());
        end else if (got_q[0] !== b0 || got_q[1] !== b1) begin
            n_fail++;
            $display("FAIL gap_data: got=%02h,%02h required=%02h,%02h", got_q[0], got_q[1], b0, b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] sent[$];
        got_q.delete();
        tick();
        ft_txe_n = 1'b1;
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
        repeat (8) tick();
        @(negedge clk);
        n_checks++;
        if (ft_wr_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_buffered: wr_n=%b required 0 before reset", ft_wr_n);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ft_wr_n !== 1'b1 || tx_count !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: wr_n=%b tx_count=%08h required 1/0", ft_wr_n, tx_count);
        end
        got_q.delete();
        ft_txe_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sent.push_back(8'($urandom));
            fifo_q.push_back(sent[i]);
        end
        for (int c = 0; c < 40 && got_q.size() < 6; c++) @(negedge clk);
        n_checks++;
        if (got_q.size() !== 6) begin
            n_fail++;
            $display("FAIL rstmid_size: got %0d bytes required 6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i] !== sent[i]) begin
                    n_fail++;
                    $display("FAIL rstmid_data[%0d]: got=%02h required=%02h", i, got_q[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        got_q.delete();
        repeat (3) tick();
        force dut.tx_count = 32'hFFFF_FFFE;
        mdl_count = 32'hFFFF_FFFE;
        tick();
        release dut.tx_count;
        @(negedge clk);
        ft_txe_n = 1'b0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
        for (int c = 0; c < 20 && got_q.size() < 3; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_count !== 32'd1) begin
            n_fail++;
            $display("FAIL wrap: tx_count=%08h required 00000001", tx_count);
        end
    endtask

    task automatic test_siwu();
        int last_acc;
        int low_q[$];
        last_acc = -1;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        ft_txe_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (ft_siwu_n !== 1'b1) begin
                n_fail++;
                $display("FAIL siwu_quiet[%0d]: ft_siwu_n=%b required 1 with no traffic", c, ft_siwu_n);
            end
        end
        got_q.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!ft_wr_n && !ft_txe_n) last_acc = cyc;
            if (!ft_siwu_n) low_q.push_back(cyc);
        end
        n_checks++;
        if (got_q.size() !== 3) begin
            n_fail++;
            $display("FAIL siwu_bytes: got %0d bytes required 3", got_q.size());
        end
`ifdef FT2_SIWU_EN
        // Idle clocks are the IDLE clocks after the accepting one; the pulse follows them.
        n_checks++;
        if (low_q.size() !== 1) begin
            n_fail++;
            $display("FAIL siwu_pulse_count: %0d low clocks required 1", low_q.size());
        end else if (low_q[0] !== last_acc + IDLE + 1) begin
            n_fail++;
            $display("FAIL siwu_pulse_time: low at cyc=%0d required cyc=%0d", low_q[0], last_acc + IDLE + 1);
        end
`else
        n_checks++;
        if (low_q.size() !== 0) begin
            n_fail++;
            $display("FAIL siwu_none: %0d low clocks required 0", low_q.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_wrap();
        test_siwu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
